// File: rtl/pmem_line_responder.sv
// rtl/pmem_line_responder.sv - fixed-latency 128-bit line store for the cache pmem side
// Optional PMEM_STATS_EN adds clr_stats/rd_count/wr_count completion counters.
module pmem_line_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINE_AW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy
`ifdef PMEM_STATS_EN
  ,
  input  logic         clr_stats,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state;
  logic [7:0]           cnt;
  logic                 op_write;
  logic [LINE_AW-1:0]   op_line;
  logic [127:0]         op_wdata;

  logic [127:0]         mem [2**LINE_AW];

  logic                 accept;
  logic                 go_resp;
  logic                 eff_write;
  logic [LINE_AW-1:0]   eff_line;
  logic [127:0]         eff_wdata;
  logic [LINE_AW-1:0]   req_line;
  logic                 unused_addr;

  assign req_line    = pmem_address[LINE_AW+3:4];
  assign unused_addr = ^{pmem_address[3:0], pmem_address[15:LINE_AW+4]};

  // With LATENCY=1 the acceptance edge is also the RESP-entry edge, so the
  // store access must use the live request rather than the latched copy.
  always_comb begin
    accept    = (state == IDLE) && (pmem_read || pmem_write);
    go_resp   = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 8'd1));
    eff_write = (state == IDLE) ? pmem_write : op_write;
    eff_line  = (state == IDLE) ? req_line   : op_line;
    eff_wdata = (state == IDLE) ? pmem_wdata : op_wdata;
  end

  // Store has no reset; rst_n gating keeps an aborted write from committing.
  always_ff @(posedge clk) begin
    if (rst_n && go_resp && eff_write)
      mem[eff_line] <= eff_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      busy       <= 1'b0;
      op_write   <= 1'b0;
      op_line    <= '0;
      op_wdata   <= '0;
    end else begin
      if (go_resp && !eff_write)
        pmem_rdata <= mem[eff_line];
      case (state)
        IDLE: begin
          pmem_resp <= 1'b0;
          if (accept) begin
            op_write <= pmem_write;
            op_line  <= req_line;
            op_wdata <= pmem_wdata;
            cnt      <= 8'(LATENCY - 1);
            busy     <= 1'b1;
            if (LATENCY == 1) begin
              state     <= RESP;
              pmem_resp <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state     <= RESP;
            pmem_resp <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          pmem_resp <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          pmem_resp <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (clr_stats) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (state == RESP) begin
      if (op_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// tb/tb_pmem_line_responder.sv - directed self-checking bench for pmem_line_responder
// Exercises PMEM_STATS_EN counters when the macro is defined.
module tb_pmem_line_responder;

  logic         clk;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         busy;
`ifdef PMEM_STATS_EN
  logic         clr_stats;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [127:0] VAL_DB = 128'hDEADBEEF_00112233_44556677_DEADBEEF;
  localparam logic [127:0] VAL_A  = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
  localparam logic [127:0] VAL_B  = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;
  localparam logic [127:0] VAL_C  = 128'hCCCC0001_CCCC0002_CCCC0003_CCCC0004;
  localparam logic [127:0] VAL_D  = 128'hDDDD0001_DDDD0002_DDDD0003_DDDD0004;

  pmem_line_responder #(.LATENCY(4), .LINE_AW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .busy         (busy)
`ifdef PMEM_STATS_EN
    ,
    .clr_stats    (clr_stats),
    .rd_count     (rd_count),
    .wr_count     (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one request, scramble address/data after acceptance, drop it on resp.
  task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [127:0] wd, input string tag, output logic [127:0] rdat);
    int k;
    @(negedge clk);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    @(posedge clk);
    @(negedge clk);
    k = 1;
    pmem_address = ~addr;
    pmem_wdata   = ~wd;
    check({tag, "_busy"}, 128'(busy), 128'd1);
    while (!pmem_resp && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 128'(k), 128'd4);
    rdat       = pmem_rdata;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 128'({pmem_resp, busy}), 128'd0);
  endtask

  initial begin
    logic [127:0] rd;
    logic         saw_resp;
    int           first_k;
    int           second_k;
    rst_n        = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0;
    pmem_wdata   = '0;
`ifdef PMEM_STATS_EN
    clr_stats    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_resp", 128'(pmem_resp), 128'd0);
      check("idle_busy", 128'(busy), 128'd0);
      check("idle_rdata", pmem_rdata, 128'd0);
    end

    do_op(1'b0, 1'b1, 16'h0050, 128'd0, "pre_w50", rd);

    // Write then read same line
    do_op(1'b0, 1'b1, 16'h0040, VAL_DB, "t2_w", rd);
    do_op(1'b1, 1'b0, 16'h0040, '0, "t2_r", rd);
    check("t2_rdata", rd, VAL_DB);

    // Aliasing and offset bits ignored
    do_op(1'b0, 1'b1, 16'h0010, VAL_A, "t3_wA", rd);
    do_op(1'b1, 1'b0, 16'h1015, '0, "t3_rA", rd);
    check("t3_alias_rdata", rd, VAL_A);
    do_op(1'b0, 1'b1, 16'h0020, VAL_B, "t3_wB", rd);
    check("t3_rdata_hold", rd, VAL_A);
    do_op(1'b1, 1'b0, 16'h0010, '0, "t3_rA2", rd);
    check("t3_still_A", rd, VAL_A);

    // Simultaneous read and write: write wins
    do_op(1'b1, 1'b1, 16'h0080, VAL_C, "t4_rw", rd);
    check("t4_rdata_hold", rd, VAL_A);
    do_op(1'b1, 1'b0, 16'h0080, '0, "t4_r", rd);
    check("t4_rdata", rd, VAL_C);

    // Back-to-back: read held high through RESP is re-accepted in the next IDLE
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 16'h0040;
    @(posedge clk);
    first_k  = 0;
    second_k = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (pmem_resp && first_k == 0) first_k = k;
      else if (pmem_resp && second_k == 0) second_k = k;
    end
    pmem_read = 1'b0;
    check("b2b_first", 128'(first_k), 128'd4);
    check("b2b_second", 128'(second_k), 128'd9);
    check("b2b_rdata", pmem_rdata, VAL_DB);
    repeat (6) @(negedge clk);

    // Reset in WAIT cycle 2 aborts the write
    @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = 16'h0050;
    pmem_wdata   = VAL_D;
    @(posedge clk);
    @(negedge clk);
    pmem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy_rst", 128'(busy), 128'd0);
    check("t5_rdata_rst", pmem_rdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pmem_resp) saw_resp = 1'b1;
    end
    check("t5_no_resp", 128'(saw_resp), 128'd0);
    do_op(1'b1, 1'b0, 16'h0050, '0, "t5_r", rd);
    check("t5_rdata_prior", rd, 128'd0);

`ifdef PMEM_STATS_EN
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    check("t6_clr_rd", 128'(rd_count), 128'd0);
    do_op(1'b1, 1'b0, 16'h0010, '0, "t6_r1", rd);
    do_op(1'b0, 1'b1, 16'h0030, VAL_B, "t6_w1", rd);
    do_op(1'b1, 1'b0, 16'h0020, '0, "t6_r2", rd);
    do_op(1'b1, 1'b1, 16'h0060, VAL_C, "t6_w2", rd);
    do_op(1'b1, 1'b0, 16'h0030, '0, "t6_r3", rd);
    check("t6_rd_count", 128'(rd_count), 128'd3);
    check("t6_wr_count", 128'(wr_count), 128'd2);
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 16'h0010;
    @(posedge clk);
    first_k = 0;
    while (!pmem_resp && first_k < 20) begin
      @(negedge clk);
      first_k++;
    end
    pmem_read = 1'b0;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    check("t6_clr_rd_resp", 128'(rd_count), 128'd0);
    check("t6_clr_wr_resp", 128'(wr_count), 128'd0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
